// File: rtl/ucode_next_state_seq.sv
// ucode_next_state_seq
//   Registered next-state sequencer for the two-address microcode control
//   unit. Each cycle one op is applied: HOLD keeps the state, JUMP loads one
//   of NUM_SRC candidate addresses, CALL loads a candidate and pushes a
//   return address, RET pops the most recent return address into the state.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   op         in   [1:0]  00 HOLD, 01 JUMP, 10 CALL, 11 RET
//   select     in   [SEL_W-1:0]  candidate index for JUMP/CALL
//   cand       in   [NUM_SRC*STATE_W-1:0]  packed candidates, i at [i*STATE_W +: STATE_W]
//   ret_addr   in   [STATE_W-1:0]  address pushed on CALL
//   state      out  [STATE_W-1:0]  registered current state
//   depth      out  [CNT_W-1:0]    valid return-stack entries
//   empty      out  depth == 0
//   full       out  depth == STACK_DEPTH
//   overflow   out  sticky: CALL attempted while full
//   underflow  out  sticky: RET attempted while empty
//
// Op table
//   op   | meaning
//   HOLD | state, stack, depth unchanged
//   JUMP | state <= candidate[select]
//   CALL | push ret_addr, state <= candidate[select]; ignored (flag) when full
//   RET  | state <= top of stack, pop; ignored (flag) when empty
module ucode_next_state_seq #(
  parameter int STATE_W     = 3,
  parameter int NUM_SRC     = 4,
  parameter int SEL_W       = 2,
  parameter int STACK_DEPTH = 4,
  parameter int CNT_W       = 3,
  parameter logic [STATE_W-1:0] RESET_STATE = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 op,
  input  logic [SEL_W-1:0]           select,
  input  logic [NUM_SRC*STATE_W-1:0] cand,
  input  logic [STATE_W-1:0]         ret_addr,
  output logic [STATE_W-1:0]         state,
  output logic [CNT_W-1:0]           depth,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_JUMP = 2'b01,
    OP_CALL = 2'b10,
    OP_RET  = 2'b11
  } op_e;

  logic [STATE_W-1:0] stack [STACK_DEPTH];

  logic [STATE_W-1:0] sel_val;
  logic [STATE_W-1:0] state_nxt;
  logic [CNT_W-1:0]   depth_nxt;
  logic               ovf_nxt;
  logic               unf_nxt;
  logic               push_en;
  logic [IDX_W-1:0]   push_idx;
  logic [IDX_W-1:0]   pop_idx;

  assign empty = (depth == '0);
  assign full  = (depth == CNT_W'(STACK_DEPTH));

  // Push writes at depth, pop reads depth-1. Only used when not full / not
  // empty respectively, so both indices are always in range when they matter.
  assign push_idx = IDX_W'(depth);
  assign pop_idx  = IDX_W'(depth - CNT_W'(1));

  // Out-of-range selects fall back to candidate 0.
  always_comb begin
    sel_val = cand[0 +: STATE_W];
    for (int i = 1; i < NUM_SRC; i++) begin
      if (int'(select) == i) sel_val = cand[i*STATE_W +: STATE_W];
    end
  end

  always_comb begin
    state_nxt = state;
    depth_nxt = depth;
    ovf_nxt   = overflow;
    unf_nxt   = underflow;
    push_en   = 1'b0;
    case (op_e'(op))
      OP_HOLD: ;
      OP_JUMP: state_nxt = sel_val;
      OP_CALL: begin
        if (full) begin
          ovf_nxt = 1'b1;
        end else begin
          state_nxt = sel_val;
          depth_nxt = depth + CNT_W'(1);
          push_en   = 1'b1;
        end
      end
      OP_RET: begin
        if (empty) begin
          unf_nxt = 1'b1;
        end else begin
          state_nxt = stack[pop_idx];
          depth_nxt = depth - CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RESET_STATE;
      depth     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state     <= state_nxt;
      depth     <= depth_nxt;
      overflow  <= ovf_nxt;
      underflow <= unf_nxt;
    end
  end

  // Stack storage is never cleared; entries at or above depth are never read.
  always_ff @(posedge clk) begin
    if (push_en && !reset) stack[push_idx] <= ret_addr;
  end

endmodule
